// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, one-entry skid buffer,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 32,
  parameter int                 NUM_OPS   = 2,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [INSTR_W-1:0]        in_instr,
  input  logic                      in_ovf,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [INSTR_W-1:0]        out_instr,
  output logic                      out_ovf,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int OPS_W = NUM_OPS * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [OPS_W-1:0]     main_ops_r;
  logic [INSTR_W-1:0]   main_instr_r;
  logic                 main_ovf_r;
  logic [OPS_W-1:0]     skid_ops_r;
  logic [INSTR_W-1:0]   skid_instr_r;
  logic                 skid_ovf_r;
  logic                 out_valid_r;
  logic                 in_ready_r;
  logic [CNT_W-1:0]     stall_cnt_r;

  logic in_fire_s;
  logic out_fire_s;
  logic main_load_in_s;
  logic main_load_skid_s;
  logic main_clear_s;
  logic skid_load_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Next-state and entry-update decode for the EMPTY/FULL/SKID handshake FSM.
  always_comb begin
    next_state_s     = state_r;
    main_load_in_s   = 1'b0;
    main_load_skid_s = 1'b0;
    main_clear_s     = 1'b0;
    skid_load_s      = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (in_fire_s) begin
          next_state_s   = ST_FULL;
          main_load_in_s = 1'b1;
        end else begin
          next_state_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (in_fire_s && out_fire_s) begin
          next_state_s   = ST_FULL;
          main_load_in_s = 1'b1;
        end else if (in_fire_s) begin
          next_state_s = ST_SKID;
          skid_load_s  = 1'b1;
        end else if (out_fire_s) begin
          next_state_s = ST_EMPTY;
          main_clear_s = 1'b1;
        end else begin
          next_state_s = ST_FULL;
        end
      end
      ST_SKID: begin
        if (out_fire_s) begin
          next_state_s     = ST_FULL;
          main_load_skid_s = 1'b1;
        end else begin
          next_state_s = ST_SKID;
        end
      end
      default: begin
        next_state_s = ST_EMPTY;
        main_clear_s = 1'b1;
      end
    endcase
  end

  // State, storage entries, registered handshake outputs and stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_EMPTY;
      main_ops_r   <= {OPS_W{1'b0}};
      main_instr_r <= NOP_INSTR;
      main_ovf_r   <= 1'b0;
      skid_ops_r   <= {OPS_W{1'b0}};
      skid_instr_r <= NOP_INSTR;
      skid_ovf_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      in_ready_r   <= 1'b1;
      stall_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      // Counter keeps running through flush; only reset clears it.
      if (out_valid_r && !out_ready && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush) begin
        state_r      <= ST_EMPTY;
        main_ops_r   <= {OPS_W{1'b0}};
        main_instr_r <= NOP_INSTR;
        main_ovf_r   <= 1'b0;
        skid_ops_r   <= {OPS_W{1'b0}};
        skid_instr_r <= NOP_INSTR;
        skid_ovf_r   <= 1'b0;
        out_valid_r  <= 1'b0;
        in_ready_r   <= 1'b1;
      end else begin
        state_r     <= next_state_s;
        out_valid_r <= (next_state_s != ST_EMPTY);
        in_ready_r  <= (next_state_s != ST_SKID);
        if (main_load_in_s) begin
          main_ops_r   <= in_ops;
          main_instr_r <= in_instr;
          main_ovf_r   <= in_ovf;
        end else if (main_load_skid_s) begin
          main_ops_r   <= skid_ops_r;
          main_instr_r <= skid_instr_r;
          main_ovf_r   <= skid_ovf_r;
        end else if (main_clear_s) begin
          main_ops_r   <= {OPS_W{1'b0}};
          main_instr_r <= NOP_INSTR;
          main_ovf_r   <= 1'b0;
        end
        if (skid_load_s) begin
          skid_ops_r   <= in_ops;
          skid_instr_r <= in_instr;
          skid_ovf_r   <= in_ovf;
        end
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_ops   = main_ops_r;
  assign out_instr = main_instr_r;
  assign out_ovf   = main_ovf_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks of pipe_stage_reg (NUM_OPS=3, DATA_W=8, CNT_W=4) followed by a
// random valid/ready stream compared against a queue model.
module tb_pipe_stage_reg;

  localparam int DATA_W  = 8;
  localparam int NUM_OPS = 3;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;
  localparam logic [INSTR_W-1:0] NOP = 32'hDEAD_0013;
  localparam int BEAT_W = NUM_OPS*DATA_W + INSTR_W + 1;

  logic                      clk = 1'b0;
  logic                      reset, flush, in_valid, in_ready, in_ovf;
  logic                      out_valid, out_ready, out_ovf;
  logic [NUM_OPS*DATA_W-1:0] in_ops, out_ops;
  logic [INSTR_W-1:0]        in_instr, out_instr;
  logic [CNT_W-1:0]          stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(
    .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .INSTR_W(INSTR_W),
    .NOP_INSTR(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
    .in_instr(in_instr), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_ops(out_ops),
    .out_instr(out_instr), .out_ovf(out_ovf), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [31:0] instr);
    in_valid = v;
    in_instr = instr;
    in_ops   = {instr[7:0], instr[7:0] ^ 8'h5A, instr[7:0] + 8'h01};
    in_ovf   = instr[0];
  endtask

  logic [BEAT_W-1:0] q[$];
  logic [BEAT_W-1:0] exp_beat;
  logic              ifire, ofire;
  int                stall_m;

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    beat(1'b0, 32'd0);

    // 1: reset
    tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_instr", out_instr, NOP);
    check("rst_out_ops", out_ops, 24'h0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_stall", stall_cnt, 4'd0);
    reset = 1'b1;

    // 2: streaming, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      beat(1'b1, i);
      tick();
      check("stream_valid", out_valid, 1'b1);
      check("stream_instr", out_instr, i);
      check("stream_in_ready", in_ready, 1'b1);
    end
    beat(1'b0, 32'd0);
    tick();
    check("stream_drain_valid", out_valid, 1'b0);
    check("stream_drain_instr", out_instr, NOP);
    check("stream_stall", stall_cnt, 4'd0);

    // 3: back-pressure through the skid entry
    out_ready = 1'b0;
    beat(1'b1, 32'hA); tick();
    check("bp_A_instr", out_instr, 32'hA);
    check("bp_A_ready", in_ready, 1'b1);
    beat(1'b1, 32'hB); tick();
    check("bp_B_held_A", out_instr, 32'hA);
    check("bp_B_ready", in_ready, 1'b0);
    check("bp_stall1", stall_cnt, 4'd1);
    beat(1'b1, 32'hC); tick();
    check("bp_C_held_A", out_instr, 32'hA);
    check("bp_C_ready", in_ready, 1'b0);
    check("bp_stall2", stall_cnt, 4'd2);
    out_ready = 1'b1; tick();
    check("bp_out_B", out_instr, 32'hB);
    check("bp_ready_back", in_ready, 1'b1);
    tick();
    check("bp_out_C", out_instr, 32'hC);
    check("bp_out_C_ops", out_ops, {8'h0C, 8'h56, 8'h0D});
    beat(1'b0, 32'd0); tick();
    check("bp_empty", out_valid, 1'b0);
    check("bp_stall_hold", stall_cnt, 4'd2);

    // 4: flush from SKID with an incoming beat
    out_ready = 1'b0;
    beat(1'b1, 32'hD); tick();
    beat(1'b1, 32'hE); tick();
    check("fl_skid_ready", in_ready, 1'b0);
    flush = 1'b1; beat(1'b1, 32'hF); tick();
    check("fl_valid", out_valid, 1'b0);
    check("fl_instr", out_instr, NOP);
    check("fl_ops", out_ops, 24'h0);
    check("fl_ready", in_ready, 1'b1);
    check("fl_stall", stall_cnt, 4'd4);
    flush = 1'b0; beat(1'b0, 32'd0); out_ready = 1'b1; tick();
    check("fl_no_F", out_valid, 1'b0);
    flush = 1'b1; beat(1'b1, 32'h6); tick();
    check("fl_drop_while_ready", out_valid, 1'b0);
    flush = 1'b0; beat(1'b0, 32'd0); tick();
    check("fl_no_G", out_valid, 1'b0);

    // 5: saturating stall counter
    out_ready = 1'b0;
    beat(1'b1, 32'h9); tick();
    beat(1'b0, 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("cnt_sat", stall_cnt, 4'd15);
    flush = 1'b1; tick(); flush = 1'b0;
    check("cnt_flush_keep", stall_cnt, 4'd15);
    check("cnt_flush_valid", out_valid, 1'b0);
    reset = 1'b0; flush = 1'b1; tick(); reset = 1'b1; flush = 1'b0;
    check("cnt_reset", stall_cnt, 4'd0);

    // 6: operand packing and overflow flag
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h77; in_ops = 24'h332211; in_ovf = 1'b1;
    tick();
    check("par_ops", out_ops, 24'h332211);
    check("par_ovf", out_ovf, 1'b1);
    check("par_instr", out_instr, 32'h77);
    beat(1'b0, 32'd0); tick();
    check("par_bubble_ops", out_ops, 24'h0);
    check("par_bubble_ovf", out_ovf, 1'b0);

    // Random valid/ready against a queue model of held beats
    reset = 1'b0; tick(); reset = 1'b1;
    stall_m = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = $urandom;
      in_ops    = $urandom;
      in_ovf    = $urandom_range(0, 1);
      ifire = in_valid && in_ready;
      ofire = out_valid && out_ready;
      if (ofire) begin
        exp_beat = q.pop_front();
        check("rnd_beat", {out_ovf, out_instr, out_ops}, exp_beat);
      end
      if (out_valid && !out_ready && stall_m < 15) stall_m++;
      if (ifire) q.push_back({in_ovf, in_instr, in_ops});
      tick();
      check("rnd_valid", out_valid, (q.size() != 0));
      check("rnd_ready", in_ready, (q.size() < 2));
      check("rnd_stall", stall_cnt, stall_m);
      if (q.size() == 0) check("rnd_nop", out_instr, NOP);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
